// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32 opcode constants, the NOP encoding and a scoreboard counter-width helper.
package riscv_pkg;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP       = 32'h00000013;

    // A zero maximum wait would give a zero-width counter, so keep at least one bit.
    function automatic int cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction
endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: ID-stage request and hazard control bundle.
// master drives id_valid/id_instr/ex_flush/mem_stall; slave (hazard unit) drives stall/bubble/flush_id/sb_busy.
interface hazard_scoreboard_unit_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_flush;
    logic        mem_stall;
    logic        stall;
    logic        bubble;
    logic        flush_id;
    logic        sb_busy;
    modport master (output id_valid, id_instr, ex_flush, mem_stall, input stall, bubble, flush_id, sb_busy);
    modport slave  (input id_valid, id_instr, ex_flush, mem_stall, output stall, bubble, flush_id, sb_busy);
endinterface

// File: rtl/hazard_reg_decode.sv
// hazard_reg_decode: extracts register fields and their use flags from an RV32 instruction.
// Ports: instr_i in; rs1_o/rs2_o/rd_o addresses; rs1_used_o/rs2_used_o/rd_wr_o/is_load_o flags (x0 never used/written).
module hazard_reg_decode
    import riscv_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [31:0]   instr_i,
    output logic [AW-1:0] rs1_o,
    output logic [AW-1:0] rs2_o,
    output logic [AW-1:0] rd_o,
    output logic          rs1_used_o,
    output logic          rs2_used_o,
    output logic          rd_wr_o,
    output logic          is_load_o
);
    logic [6:0] opc;
    logic       is_r, is_ialu, is_store, is_branch, is_jalr;
    logic       unused_ok;
    assign unused_ok  = ^instr_i;
    assign opc        = instr_i[6:0];
    assign is_r       = opc == OPC_R;
    assign is_ialu    = opc == OPC_IALU;
    assign is_load_o  = opc == OPC_LOAD;
    assign is_store   = opc == OPC_STORE;
    assign is_branch  = opc == OPC_BRANCH;
    assign is_jalr    = opc == OPC_JALR;
    assign rs1_o      = instr_i[15 +: AW];
    assign rs2_o      = instr_i[20 +: AW];
    assign rd_o       = instr_i[7 +: AW];
    assign rs1_used_o = (is_r | is_ialu | is_load_o | is_store | is_branch | is_jalr) & (rs1_o != '0);
    assign rs2_used_o = (is_r | is_store | is_branch) & (rs2_o != '0);
    assign rd_wr_o    = (is_r | is_ialu | is_load_o | is_jalr | opc == OPC_LUI | opc == OPC_AUIPC | opc == OPC_JAL)
                        & (rd_o != '0);
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: per-register countdown scoreboard driving ID stall, EX bubble and branch flush.
// Ports: clk, rst (sync, active-low), bus (hazard_scoreboard_unit_if.slave).
// Config: define HAZARD_FWD_EN for a forwarding pipeline; undefined means no bypass (every writer waits NOFWD_STALL).
module hazard_scoreboard_unit
    import riscv_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int LOAD_LATENCY = 2,
    parameter int NOFWD_STALL  = 2
) (
    input logic                      clk,
    input logic                      rst,
    hazard_scoreboard_unit_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int LW = LOAD_LATENCY - 1;
`ifdef HAZARD_FWD_EN
    localparam int MAXW = LW;
    localparam int ALUW = 0;
`else
    localparam int MAXW = (NOFWD_STALL > LW) ? NOFWD_STALL : LW;
    localparam int ALUW = NOFWD_STALL;
`endif
    localparam int CW = cnt_width(MAXW);

    logic [AW-1:0]       rs1, rs2, rd;
    logic                rs1_used, rs2_used, rd_wr, is_load;
    logic [NUM_REGS-1:0] busy;
    logic [CW-1:0]       wait_v;
    logic                hz, issue;

    hazard_reg_decode #(.AW(AW)) u_dec (
        .instr_i    (bus.id_instr),
        .rs1_o      (rs1),
        .rs2_o      (rs2),
        .rd_o       (rd),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used),
        .rd_wr_o    (rd_wr),
        .is_load_o  (is_load)
    );

    assign wait_v = is_load ? CW'(MAXW) : CW'(ALUW);
    assign hz     = bus.id_valid & ((rs1_used & busy[rs1]) | (rs2_used & busy[rs2]));
    assign issue  = bus.id_valid & ~hz & ~bus.mem_stall & ~bus.ex_flush;
    assign busy[0] = 1'b0;

    // A reload on issue overrides the decrement; mem_stall freezes every entry.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic [CW-1:0] cnt_q, cnt_d;
        always_comb cnt_d = bus.mem_stall ? cnt_q
                          : (issue && rd_wr && rd == AW'(r)) ? wait_v
                          : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        always_ff @(posedge clk)
            if (!rst) cnt_q <= '0;
            else cnt_q <= cnt_d;
        assign busy[r] = cnt_q != '0;
    end

    assign bus.stall    = rst & (bus.mem_stall | (~bus.ex_flush & hz));
    assign bus.bubble   = rst & ~bus.mem_stall & (bus.ex_flush | hz);
    assign bus.flush_id = rst & ~bus.mem_stall & bus.ex_flush;
    assign bus.sb_busy  = rst & (|busy);
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed checks of the hazard scoreboard with LOAD_LATENCY=2 and LOAD_LATENCY=4 instances.
module tb_hazard_scoreboard_unit;
    import riscv_pkg::*;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // Instance A: LOAD_LATENCY=2, NOFWD_STALL=2. Instance B: LOAD_LATENCY=4, NOFWD_STALL=1.
    localparam int LW_A  = FWD ? 1 : 2;
    localparam int ALU_A = FWD ? 0 : 2;
    localparam int LW_B  = 3;

    localparam logic [31:0] I_LW5  = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] I_LW0  = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] I_ADD6 = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] I_SW5  = 32'h0051A023; // sw   x5,0(x3)
    localparam logic [31:0] I_ADDI = 32'h00540393; // addi x7,x8,5
    localparam logic [31:0] I_ADD5 = 32'h002082B3; // add  x5,x1,x2
    localparam logic [31:0] I_SUB6 = 32'h40128333; // sub  x6,x5,x1

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_unit_if ifa();
    hazard_scoreboard_unit_if ifb();

    hazard_scoreboard_unit #(.NUM_REGS(32), .LOAD_LATENCY(2), .NOFWD_STALL(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );
    hazard_scoreboard_unit #(.NUM_REGS(32), .LOAD_LATENCY(4), .NOFWD_STALL(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    int checks = 0;
    int failures = 0;
    int n;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drv(input bit v, input logic [31:0] ins, input bit fl, input bit ms);
        ifa.id_valid = v; ifa.id_instr = ins; ifa.ex_flush = fl; ifa.mem_stall = ms;
        ifb.id_valid = v; ifb.id_instr = ins; ifb.ex_flush = fl; ifb.mem_stall = ms;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive stall cycles of the held instruction, then lets it issue.
    task automatic stalls(input bit sel_b, output int cnt);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!(sel_b ? ifb.stall : ifa.stall)) begin
                tick();
                return;
            end
            cnt++;
            check("stall_bubble", int'(sel_b ? ifb.bubble : ifa.bubble), 1);
            tick();
        end
    endtask

    task automatic drain();
        drv(0, NOP, 0, 0);
        repeat (5) tick();
        @(negedge clk);
        check("drain_a", int'(ifa.sb_busy), 0);
        check("drain_b", int'(ifb.sb_busy), 0);
        tick();
    endtask

    initial begin
        drv(1, I_ADD6, 1, 1);
        tick();
        tick();
        @(negedge clk);
        check("rst_stall", int'(ifa.stall), 0);
        check("rst_bubble", int'(ifa.bubble), 0);
        check("rst_flush", int'(ifa.flush_id), 0);
        check("rst_busy", int'(ifa.sb_busy), 0);
        tick();
        rst = 1'b1;
        drv(0, NOP, 0, 0);
        @(negedge clk);
        check("post_rst_busy", int'(ifa.sb_busy), 0);
        tick();

        // load-use, LOAD_LATENCY=2
        drv(1, I_LW5, 0, 0);
        @(negedge clk);
        check("lw_nostall", int'(ifa.stall), 0);
        tick();
        drv(1, I_ADD6, 0, 0);
        stalls(0, n);
        check("loaduse_a", n, LW_A);
        drain();

        // LOAD_LATENCY=4, store uses x5 as rs2
        drv(1, I_LW5, 0, 0);
        tick();
        drv(1, I_SW5, 0, 0);
        stalls(1, n);
        check("ld4_sw", n, LW_B);
        drain();
        drv(1, I_LW0, 0, 0);
        tick();
        drv(1, I_SW5, 0, 0);
        stalls(1, n);
        check("ld0_sw", n, 0);
        drain();

        // I-type: rs2 field aliases x5 but is unused
        drv(1, I_LW5, 0, 0);
        tick();
        drv(1, I_ADDI, 0, 0);
        @(negedge clk);
        check("addi_stall", int'(ifa.stall), 0);
        check("addi_busy", int'(ifa.sb_busy), 1);
        tick();
        drain();

        // mem_stall in the middle of a load-use stall
        drv(1, I_LW5, 0, 0);
        tick();
        drv(1, I_ADD6, 0, 0);
        @(negedge clk);
        check("ms_pre_stall", int'(ifa.stall), 1);
        check("ms_pre_bubble", int'(ifa.bubble), 1);
        tick();
        drv(1, I_ADD6, 0, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("ms_stall", int'(ifa.stall), 1);
            check("ms_bubble", int'(ifa.bubble), 0);
            check("ms_flush", int'(ifa.flush_id), 0);
            check("ms_frozen", int'(ifa.sb_busy), int'(LW_A > 1));
            tick();
        end
        drv(1, I_ADD6, 0, 0);
        stalls(0, n);
        check("ms_total", n + 3, LW_A + 2);
        drain();

        // flush while stalled
        drv(1, I_LW5, 0, 0);
        tick();
        drv(1, I_ADD6, 1, 0);
        @(negedge clk);
        check("fl_flush", int'(ifa.flush_id), 1);
        check("fl_bubble", int'(ifa.bubble), 1);
        check("fl_stall", int'(ifa.stall), 0);
        check("fl_busy0", int'(ifa.sb_busy), 1);
        tick();
        drv(0, NOP, 0, 0);
        @(negedge clk);
        check("fl_busy1", int'(ifa.sb_busy), int'(LW_A > 1));
        tick();
        @(negedge clk);
        check("fl_busy2", int'(ifa.sb_busy), 0);
        tick();

        // ALU-ALU dependency
        drv(1, I_ADD5, 0, 0);
        tick();
        drv(1, I_SUB6, 0, 0);
        stalls(0, n);
        check("alu_alu", n, ALU_A);
        drain();

        // reset during the first dependent-stall cycle
        drv(1, I_ADD5, 0, 0);
        tick();
        drv(1, I_SUB6, 0, 0);
        @(negedge clk);
        check("rs_pre_stall", int'(ifa.stall), int'(ALU_A != 0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rs_stall", int'(ifa.stall), 0);
        check("rs_bubble", int'(ifa.bubble), 0);
        check("rs_busy", int'(ifa.sb_busy), 0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rs_after_stall", int'(ifa.stall), 0);
        check("rs_after_busy", int'(ifa.sb_busy), 0);
        tick();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised load/writer hazard unit for the in-order RISC-V pipeline, sitting beside the ID stage. It decodes the ID instruction, tracks in-flight register writers in a per-register countdown scoreboard, and drives front-end stall, EX bubble and branch flush. It replaces the single-cycle load-use comparator:
- supports multi-cycle loads;
- ignores x0 and unused source fields;
- honours data-memory back-pressure;
- optionally supports a no-forwarding pipeline.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; register address width is $clog2(NUM_REGS).
- LOAD_LATENCY, 2: cycles from load entering EX to data being forwardable. Legal range 1..8.
- NOFWD_STALL, 2: stall cycles for any writer when forwarding is compiled out.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, synchronous, active-low.
- id_valid, in, 1: IF/ID holds a valid instruction.
- id_instr, in, 32: IF/ID instruction word.
- ex_flush, in, 1: branch/jump taken, resolved in EX.
- mem_stall, in, 1: data memory busy; the whole pipe freezes.
- stall, out, 1: hold PC and IF/ID.
- bubble, out, 1: zero the ID/EX control bits.
- flush_id, out, 1: replace IF/ID with a NOP.
- sb_busy, out, 1: some scoreboard counter is non-zero.

## Operation
- Decode (opcode id_instr[6:0]):
  - rs1 is used for R, I-ALU, LOAD, STORE, BRANCH and JALR.
  - rs2 is used for R, STORE and BRANCH.
  - rd is written for R, I-ALU, LOAD, LUI, AUIPC, JAL and JALR.
  - A field addressing x0 is treated as unused or not written.
- Scoreboard: counter cnt[r] per register, width $clog2(max wait + 1); x0 has no entry.
- Hazard: hz = id_valid & ((rs1_used & cnt[rs1]!=0) | (rs2_used & cnt[rs2]!=0)).
- Issue: issue = id_valid & ~hz & ~mem_stall & ~ex_flush.
- On issue with rd written, cnt[rd] is loaded as follows:
  - load: LOAD_LATENCY-1;
  - other writer: 0.
  - Without forwarding, see Configuration.
- Each cycle with mem_stall=0, every non-zero cnt decrements by 1. A load of cnt[rd] in the same cycle overrides the decrement for that entry.
- Output priority, highest first:
  1. mem_stall=1: stall=1, bubble=0, flush_id=0. Counters are frozen and ex_flush is ignored; the branch unit holds ex_flush until mem_stall drops.
  2. ex_flush=1: flush_id=1, bubble=1, stall=0, no issue.
  3. hz=1: stall=1, bubble=1.
  4. Otherwise all outputs are 0.
- sb_busy = OR of all (cnt != 0).

## Timing
- Reset (rst=0 at an edge) clears all counters. While rst=0, all outputs are forced to 0.
- Outputs are combinational from the counters and current inputs; there is no added latency.
- Load-use example, LOAD_LATENCY=2: the load issues at edge t; the consumer sits in ID in cycle t+1 with cnt=1, so stall=1. The counter decrements at edge t+1; the consumer issues in cycle t+2. Exactly 1 bubble.
- In general, a dependent instruction directly after a load sees LOAD_LATENCY-1 bubbles, plus one extra per mem_stall cycle.
- A consumer issuing in the same cycle a counter reaches 0 is legal; only cnt!=0 stalls.
- An instruction that is both consumer and producer of the same register (e.g. lw x5,0(x5)) checks the old cnt, then reloads.
- A flush while stalled drops the stalled instruction; the counters continue to decrement.
- Reset mid-stall: all counters are cleared and the next instruction issues without stalling.

## Configuration
- HAZARD_FWD_EN defined: loads use LOAD_LATENCY-1; non-load writers load 0, so no ALU-ALU stall.
- HAZARD_FWD_EN undefined: every writer loads NOFWD_STALL, and loads load max(NOFWD_STALL, LOAD_LATENCY-1). This matches a pipeline with no bypass and a write-first register file.

## Structure
- riscv_pkg holds:
  - opcode localparams: OPC_R, OPC_IALU, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC;
  - NOP encoding 32'h00000013.
- One sub-module, hazard_reg_decode: combinational. It takes id_instr and produces rs1, rs2, rd, rs1_used, rs2_used, rd_wr and is_load.
- The top level holds the counter array, hazard compare and priority logic.

## Test plan
- FWD on, LOAD_LATENCY=2: lw x5,0(x1) then add x6,x5,x2 -> stall=bubble=1 for exactly 1 cycle; add issues on the following cycle.
- LOAD_LATENCY=4: lw x5 then sw x5,0(x3), where x5 is the rs2 use -> 3 stall cycles. The same sequence with lw x0 -> 0 stalls.
- addi x7,x8,5 with instr[24:20]=5 behind lw x5 -> no stall, because rs2 is unused for I-type.
- lw x5, then the consumer stalls, with mem_stall=1 held 2 cycles in the middle -> stall is held and cnt is frozen; total stall is 3 cycles, with bubble=0 during mem_stall.
- Consumer stalled, ex_flush=1 -> flush_id=1, bubble=1, stall=0 that cycle; the instruction is not issued and sb_busy drops 1 cycle later.
- FWD off, NOFWD_STALL=2: add x5 then sub x6,x5,x1 -> 2 stalls. Assert rst=0 during the first stall -> outputs 0 next cycle and sb_busy=0.
